// File: rtl/oh_norn_filt.sv
// Multi-channel NOR/OR/NAND/AND reduction with a per-channel stability filter.
// Each channel provides a debounced level, rise/fall pulses and a sticky status bit.
module oh_norn_filt #(
  parameter int unsigned N     = 2,
  parameter int unsigned CH    = 1,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SYNC  = 0
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            en,
  input  logic [1:0]      mode,
  input  logic [CH*N-1:0] in,
  input  logic [CH-1:0]   clear,
  output logic [CH-1:0]   z,
  output logic [CH-1:0]   rise,
  output logic [CH-1:0]   fall,
  output logic [CH-1:0]   sticky
);

  localparam int unsigned CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StInit, StStable, StPend} state_e;

  state_e          state_q [CH];
  logic [CW-1:0]   cnt_q   [CH];
  logic [CH-1:0]   z_q, rise_q, fall_q, sticky_q;
  logic [CH*N-1:0] in_s;
  logic [CH-1:0]   raw;
  logic [CH-1:0]   flip;

  if (SYNC != 0) begin : g_sync
    logic [CH*N-1:0] sync1_q, sync2_q;
    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        sync1_q <= '0;
        sync2_q <= '0;
      end else begin
        sync1_q <= in;
        sync2_q <= sync1_q;
      end
    end
    assign in_s = sync2_q;
  end else begin : g_nosync
    assign in_s = in;
  end

  function automatic logic reduce(input logic [1:0] m, input logic [N-1:0] v);
    case (m)
      2'b00:   return ~(|v);
      2'b01:   return |v;
      2'b10:   return ~(&v);
      default: return &v;
    endcase
  endfunction

  always_comb begin
    raw = '0;
    for (int c = 0; c < CH; c++) begin
      raw[c] = reduce(mode, in_s[c*N +: N]);
    end
  end

  // flip marks the edge at which a channel's z toggles; it drives pulses and sticky.
  always_comb begin
    flip = '0;
    for (int c = 0; c < CH; c++) begin
      if (en && (raw[c] != z_q[c])) begin
        case (state_q[c])
          StStable: flip[c] = (DEPTH == 1);
          StPend:   flip[c] = (cnt_q[c] == CW'(DEPTH - 1));
          default:  flip[c] = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      z_q      <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      sticky_q <= '0;
      for (int c = 0; c < CH; c++) begin
        state_q[c] <= StInit;
        cnt_q[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        rise_q[c] <= flip[c] & ~z_q[c];
        fall_q[c] <= flip[c] & z_q[c];
        if (flip[c]) begin
          sticky_q[c] <= 1'b1;
        end else if (clear[c]) begin
          sticky_q[c] <= 1'b0;
        end
        if (en) begin
          case (state_q[c])
            StInit: begin
              z_q[c]     <= raw[c];
              state_q[c] <= StStable;
            end
            StStable: begin
              if (flip[c]) begin
                z_q[c] <= ~z_q[c];
              end else if (raw[c] != z_q[c]) begin
                cnt_q[c]   <= CW'(1);
                state_q[c] <= StPend;
              end
            end
            StPend: begin
              if (raw[c] == z_q[c] || flip[c]) begin
                if (flip[c]) z_q[c] <= ~z_q[c];
                cnt_q[c]   <= '0;
                state_q[c] <= StStable;
              end else begin
                cnt_q[c] <= cnt_q[c] + CW'(1);
              end
            end
            default: begin
              cnt_q[c]   <= '0;
              state_q[c] <= StInit;
            end
          endcase
        end
      end
    end
  end

  assign z      = z_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign sticky = sticky_q;

endmodule
